// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave  : the LSU itself.
// master : the environment, meaning the core's memory stage plus the data memory.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wd;
    logic                  mem_we;
    logic [31:0]           mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit in front of a word-addressed data memory.
// The memory has a combinational read and a word-wide synchronous write,
// so sub-word stores are done as read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// take the error path instead of silently ignoring the low address bits.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    lsu_mem_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic                  w_req_ready;
    logic                  w_mem_we;
    logic                  w_resp_valid;
    logic                  w_req_err;

    // Pick the addressed byte/halfword out of a memory word and extend it.
    function automatic logic [31:0] f_load_extract(input logic [31:0] word,
                                                   input logic [2:0]  f3,
                                                   input logic [1:0]  lane);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] sx;
        logic        [31:0] res;
        b   = word[{lane, 3'b000} +: 8];
        h   = lane[1] ? word[31:16] : word[15:0];
        sx  = '0;
        res = word;
        case (f3[1:0])
            2'b00: begin
                sx  = $signed(b);
                res = f3[2] ? {24'd0, b} : sx;
            end
            2'b01: begin
                sx  = $signed(h);
                res = f3[2] ? {16'd0, h} : sx;
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Merge store data into the word read back from memory.
    function automatic logic [31:0] f_store_merge(input logic [31:0] word,
                                                  input logic [31:0] wdata,
                                                  input logic [2:0]  f3,
                                                  input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (f3[1:0])
            2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = wdata[15:0];
                else         res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Classify the incoming request: illegal funct3 (and optionally misalignment).
    always_comb begin
        w_req_err = 1'b0;
        if (bus.req_we)
            w_req_err = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
        else
            w_req_err = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3[2] & bus.req_funct3[1]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
            w_req_err = 1'b1;
        if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            w_req_err = 1'b1;
`endif
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_mem_we     = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_req_err)                        w_state_nxt = RESP;
                    else if (!bus.req_we)                 w_state_nxt = LOAD;
                    else if (bus.req_funct3[1:0] == 2'b10) w_state_nxt = STORE;
                    else                                  w_state_nxt = RMW_RD;
                end
            end
            LOAD:   w_state_nxt = RESP;
            RMW_RD: w_state_nxt = STORE;
            STORE: begin
                w_mem_we    = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, merge buffer and response registers. Response fields
    // change only when a request completes, so they hold between requests.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_buf    <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        if (w_req_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= f_load_extract(bus.mem_rd, r_funct3, r_addr[1:0]);
                    r_err   <= 1'b0;
                end
                RMW_RD: r_buf <= bus.mem_rd;
                STORE: begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_we     = w_mem_we;
    // Loads never write; keep the write bus quiet for them.
    assign bus.mem_wd     = r_we ? f_store_merge(r_buf, r_wdata, r_funct3, r_addr[1:0]) : 32'd0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 16-word memory model and a
// response scoreboard. Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst;
    logic mem_init;
    logic [31:0] mem [0:15];
    int tests;
    int fails;
    int we_cnt;
    int rv_cnt;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } exp_t;
    exp_t sb[$];

    lsu_mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h8899AABB;
            mem[1] <= 32'h11223344;
            mem[2] <= 32'hCAFEF00D;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wd;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_we)     we_cnt++;
        if (bus.resp_valid) rv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.req_ready) chk({tag, " ready_timeout"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_we);
        exp_t e;
        exp_t got;
        int cyc;
        int we0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.we    = exp_we;
        sb.push_back(e);
        wait_ready(tag);
        we0            = we_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        cyc = 1;
        while (!bus.resp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = sb.pop_front();
        chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, " latency"}, cyc, got.lat);
        chk({tag, " rdata"}, bus.resp_rdata, got.rdata);
        chk({tag, " err"}, {31'd0, bus.resp_err}, {31'd0, got.err});
        chk({tag, " we_pulses"}, we_cnt - we0, got.we);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int we0;
        int rv0;
        tests = 0;
        fails = 0;
        we_cnt = 0;
        rv_cnt = 0;
        rst = 1'b1;
        mem_init = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        chk("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wd", bus.mem_wd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req("LB 1",  1'b0, 3'b000, 32'h1, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        do_req("LBU 1", 1'b0, 3'b100, 32'h1, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        do_req("LH 2",  1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        do_req("LHU 2", 1'b0, 3'b101, 32'h2, 32'h0, 32'h00008899, 1'b0, 2, 0);
        do_req("LB 3",  1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
        do_req("LW 0",  1'b0, 3'b010, 32'h0, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
        @(posedge clk); #1;
        chk("LW hold rdata", bus.resp_rdata, 32'h8899AABB);
        chk("LW pulse width", {31'd0, bus.resp_valid}, 32'd0);

        do_req("SB 6", 1'b1, 3'b000, 32'h6, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1);
        chk("SB 6 word", mem[1], 32'h11EF3344);
        do_req("SH 4", 1'b1, 3'b001, 32'h4, 32'h0000CAFE, 32'h0, 1'b0, 3, 1);
        chk("SH 4 word", mem[1], 32'h11EFCAFE);

        do_req("LD f3=011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("LW 4",      1'b0, 3'b010, 32'h4, 32'h0, 32'h11EFCAFE, 1'b0, 2, 0);
        do_req("ST f3=100", 1'b1, 3'b100, 32'h8, 32'h55555555, 32'h0, 1'b1, 1, 0);
        chk("ST f3=100 word", mem[2], 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("SW 3", 1'b1, 3'b010, 32'h3, 32'h12345678, 32'h0, 1'b1, 1, 0);
        chk("SW 3 word", mem[0], 32'h8899AABB);
`else
        do_req("SW 3", 1'b1, 3'b010, 32'h3, 32'h12345678, 32'h0, 1'b0, 2, 1);
        chk("SW 3 word", mem[0], 32'h12345678);
`endif

        // Abort an SB during its read phase.
        wait_ready("RST SB");
        we0 = we_cnt;
        rv0 = rv_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h8;
        bus.req_wdata  = 32'h000000AB;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("RST SB in RMW ready", {31'd0, bus.req_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("RST SB mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("RST SB ready in rst", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("RST SB we_pulses", we_cnt - we0, 32'd0);
        chk("RST SB resp pulses", rv_cnt - rv0, 32'd0);
        chk("RST SB word", mem[2], 32'hCAFEF00D);
        chk("RST SB ready after", {31'd0, bus.req_ready}, 32'd1);

        do_req("LB 9 post", 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
